mips_memctrl: RTL and testbench

MIPS_MEMCTRL -- requirements
Module: mips_memctrl

---
 rtl/mips_memctrl_if.sv | 40 ++++
 rtl/mips_memctrl.sv | 145 ++++++++++++++
 tb/tb_mips_memctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_memctrl_if.sv
// mips_memctrl_if -- bundle of the CPU-side strobes and the external bus
// signals used by mips_memctrl.
//
//   CPU side : memread, memwrite, addr, writedata   (into the controller)
//              readdata, memready, busy, memerr,
//              errcnt                               (out of the controller)
//   Bus side : mem_req, mem_we, mem_addr, mem_wdata (out of the controller)
//              mem_rdata, mem_ack                   (into the controller)
//
// Modport slave is the controller's view; master is the view of whatever
// plays both the control FSM and the memory (e.g. a testbench).
interface mips_memctrl_if;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        memready;
  logic        busy;
  logic        memerr;
  logic [7:0]  errcnt;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  memread, memwrite, addr, writedata, mem_rdata, mem_ack,
    output readdata, memready, busy, memerr, errcnt,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output memread, memwrite, addr, writedata, mem_rdata, mem_ack,
    input  readdata, memready, busy, memerr, errcnt,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips_memctrl.sv
// mips_memctrl -- memory controller between a multicycle MIPS control FSM
// and an external request/acknowledge bus.
//
// Ports:
//   clk   : system clock, all state updates on the rising edge
//   reset : asynchronous, active-low
//   bus   : mips_memctrl_if.slave (CPU strobes/data and external bus)
// Parameter:
//   TIMEOUT : maximum REQ cycles spent waiting for mem_ack (1..255)
//
// A strobe in IDLE is accepted (write wins over read). Misaligned addresses
// complete immediately with an error and never touch the bus. Aligned ones
// hold mem_req until mem_ack or TIMEOUT cycles elapse, then spend exactly
// one DONE cycle pulsing memready.
module mips_memctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic           clk,
  input logic           reset,
  mips_memctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Wait count value present during the TIMEOUT-th REQ cycle.
  localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  r_errcnt;
  logic        r_err;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_readdata;

  logic w_accept;
  logic w_misaligned;
  logic w_timeout;
  logic w_mem_req;
  logic w_memready;
  logic w_busy;
  logic w_memerr;

  assign w_accept     = (r_state == S_IDLE) && (bus.memread || bus.memwrite);
  assign w_misaligned = (bus.addr[1:0] != 2'b00);
  assign w_timeout    = (r_wait_cnt == LP_LAST_WAIT);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // the values that existed before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic. An ack on the last wait cycle wins over the timeout
  // simply because both lead to DONE; the error flag below picks the ack.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal
    // unassigned, which would infer a latch.
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = w_misaligned ? S_DONE : S_REQ;
      S_REQ:  if (bus.mem_ack || w_timeout) w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    w_mem_req  = 1'b0;
    w_memready = 1'b0;
    w_busy     = 1'b0;
    w_memerr   = 1'b0;
    case (r_state)
      S_REQ: begin
        w_mem_req = 1'b1;
        w_busy    = 1'b1;
      end
      S_DONE: begin
        w_memready = 1'b1;
        w_busy     = 1'b1;
        w_memerr   = r_err;
      end
      default: ;
    endcase
  end

  // Captured request, wait counter, read data and error bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the data registers are reset as well, because readdata,
      // mem_addr, mem_wdata and errcnt must read zero as soon as reset falls.
      r_wait_cnt <= '0;
      r_errcnt   <= '0;
      r_err      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_readdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= bus.addr;
        r_wdata <= bus.writedata;
        r_we    <= bus.memwrite;
        r_err   <= w_misaligned;
      end

      // Entering REQ is only possible from IDLE, so clearing there is
      // the same as clearing on entry.
      if (r_state == S_IDLE)                      r_wait_cnt <= '0;
      else if (r_state == S_REQ && !bus.mem_ack)  r_wait_cnt <= r_wait_cnt + 8'd1;

      if (r_state == S_REQ) begin
        if (bus.mem_ack) begin
          r_err <= 1'b0;
          if (!r_we) r_readdata <= bus.mem_rdata;
        end else if (w_timeout) begin
          r_err <= 1'b1;
        end
      end

      if (r_state == S_DONE && r_err && r_errcnt != 8'hFF)
        r_errcnt <= r_errcnt + 8'd1;
    end
  end

  assign bus.mem_req   = w_mem_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.memready  = w_memready;
  assign bus.busy      = w_busy;
  assign bus.memerr    = w_memerr;
  assign bus.readdata  = r_readdata;
  assign bus.errcnt    = r_errcnt;

endmodule

// File: tb/tb_mips_memctrl.sv
// tb_mips_memctrl -- scoreboard bench for mips_memctrl.
//
// The driver issues transactions and, from the protocol rules alone
// (alignment, ack cycle vs TIMEOUT, read/write), predicts the completion:
// error flag, readdata, errcnt, number of mem_req cycles and total busy
// cycles. A responder process plays the memory and acks on a planned REQ
// cycle; a monitor pops the prediction whenever memready appears.
module tb_mips_memctrl;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_memctrl_if bus();

  mips_memctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  errcnt;
    int          req_cycles;
  } exp_t;

  typedef struct {
    int          ack_at;   // 1-based REQ cycle carrying mem_ack, 0 = never
    logic [31:0] rdata;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_readdata = '0;
  logic [7:0]  model_errcnt   = '0;
  logic        force_ack      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // Memory responder: acks on the planned REQ cycle, otherwise noise on
  // mem_ack/mem_rdata outside REQ, which the controller must ignore.
  initial begin : responder
    int n;
    n = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        n = 0;
        plan_q.delete();
        bus.mem_ack   = force_ack;
        bus.mem_rdata = $urandom;
      end else if (bus.mem_req) begin
        n++;
        if (plan_q.size() > 0 && n == plan_q[0].ack_at) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = plan_q[0].rdata;
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = $urandom;
        end
      end else begin
        if (n > 0) begin
          void'(plan_q.pop_front());
          n = 0;
        end
        bus.mem_ack   = force_ack ? 1'b1 : 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
      end
    end
  end

  // Monitor: bus stability during REQ, and completion checks at memready.
  initial begin : monitor
    int   bcnt;
    int   rcnt;
    logic prev_ready;
    exp_t e;
    bcnt = 0;
    rcnt = 0;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        bcnt = 0;
        rcnt = 0;
        prev_ready = 1'b0;
      end else begin
        if (bus.busy) bcnt++;
        if (bus.mem_req) begin
          rcnt++;
          if (exp_q.size() > 0) begin
            check("mem_addr during REQ", bus.mem_addr, exp_q[0].addr);
            check("mem_wdata during REQ", bus.mem_wdata, exp_q[0].wdata);
            check("mem_we during REQ", 32'(bus.mem_we), 32'(exp_q[0].we));
          end
        end
        if (bus.memready) begin
          check("memready single cycle", 32'(prev_ready), 32'd0);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected memready: got 1, expected 0 at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("memerr", 32'(bus.memerr), 32'(e.err));
            check("readdata", bus.readdata, e.rdata);
            check("errcnt", 32'(bus.errcnt), 32'(e.errcnt));
            check("mem_req cycles", 32'(rcnt), 32'(e.req_cycles));
            check("busy cycles", 32'(bcnt), 32'(e.req_cycles + 1));
          end
          bcnt = 0;
          rcnt = 0;
        end
        prev_ready = bus.memready;
      end
    end
  end

  // Wait for memready with a cycle budget; requester keeps strobes high.
  // Address/data wiggle while the block is in REQ and must not matter.
  task automatic wait_ready();
    for (int i = 0; i < TIMEOUT + 20; i++) begin
      @(negedge clk);
      if (bus.memready) return;
      if (bus.busy) begin
        bus.addr      = $urandom;
        bus.writedata = $urandom;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL memready wait: got no memready, expected one within %0d cycles", TIMEOUT + 20);
    finish_test();
  endtask

  // Issue one transaction from a negedge and predict its completion.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input int ack_at, input logic [31:0] rdat);
    exp_t  e;
    plan_t p;
    bus.memread   = rd;
    bus.memwrite  = wr;
    bus.addr      = a;
    bus.writedata = wd;
    e.addr   = a;
    e.wdata  = wd;
    e.we     = wr;
    e.errcnt = model_errcnt;
    if (a[1:0] != 2'b00) begin
      e.err        = 1'b1;
      e.req_cycles = 0;
    end else begin
      p.ack_at = ack_at;
      p.rdata  = rdat;
      plan_q.push_back(p);
      if (ack_at >= 1 && ack_at <= TIMEOUT) begin
        e.err        = 1'b0;
        e.req_cycles = ack_at;
        if (!wr) model_readdata = rdat;
      end else begin
        e.err        = 1'b1;
        e.req_cycles = TIMEOUT;
      end
    end
    if (e.err && model_errcnt != 8'd255) model_errcnt = model_errcnt + 8'd1;
    e.rdata = model_readdata;
    exp_q.push_back(e);
    wait_ready();
  endtask

  task automatic idle(input int n);
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin : driver
    logic [31:0] a;
    int          sel;
    int          ack_at;
    int          seen;
    plan_t       p;

    reset         = 1'b0;
    bus.memread   = 1'b0;
    bus.memwrite  = 1'b0;
    bus.addr      = '0;
    bus.writedata = '0;
    repeat (2) @(negedge clk);

    check("reset mem_req", 32'(bus.mem_req), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset memready", 32'(bus.memready), 32'd0);
    check("reset memerr", 32'(bus.memerr), 32'd0);
    check("reset readdata", bus.readdata, 32'd0);
    check("reset errcnt", 32'(bus.errcnt), 32'd0);
    check("reset mem_addr", bus.mem_addr, 32'd0);
    check("reset mem_wdata", bus.mem_wdata, 32'd0);
    check("reset mem_we", 32'(bus.mem_we), 32'd0);

    reset = 1'b1;
    idle(2);

    // Aligned read acked in the first REQ cycle.
    issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'h1234_ABCD);
    check("read data captured", bus.readdata, 32'h1234_ABCD);
    idle(1);

    // Write with three wait states; readdata untouched.
    issue(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4, 32'hDEAD_0000);
    check("write keeps readdata", bus.readdata, 32'h1234_ABCD);
    idle(1);

    // Timeout with no ack, then ack exactly on the last cycle.
    issue(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 32'h5555_5555);
    idle(1);
    check("errcnt after timeout", 32'(bus.errcnt), 32'd1);
    issue(1'b1, 1'b0, 32'h0000_0044, 32'h0, TIMEOUT, 32'h600D_F00D);
    idle(1);
    check("ack on last cycle data", bus.readdata, 32'h600D_F00D);

    // Misaligned read, then simultaneous strobes (treated as write).
    issue(1'b1, 1'b0, 32'h0000_0006, 32'h0, 1, 32'h1111_1111);
    idle(1);
    issue(1'b1, 1'b1, 32'h0000_0030, 32'h0000_0077, 2, 32'h0BAD_0BAD);
    check("both strobes keep readdata", bus.readdata, 32'h600D_F00D);

    // Back-to-back: strobes stay high into the IDLE cycle after DONE.
    issue(1'b1, 1'b0, 32'h0000_0050, 32'h0, 1, 32'hA5A5_0001);
    issue(1'b0, 1'b1, 32'h0000_0054, 32'h1357_9BDF, 3, 32'h0);
    issue(1'b1, 1'b0, 32'h0000_0005, 32'h0, 1, 32'h0);
    idle(1);

    // Randomised mix.
    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 3);
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      ack_at = ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(1, TIMEOUT + 2);
      issue(sel != 1, sel == 1 || sel == 2, a, $urandom, ack_at, $urandom);
      sel = $urandom_range(0, 2);
      if (sel > 0) idle(sel);
    end
    idle(1);

    // Saturate the error counter with misaligned requests.
    for (int i = 0; i < 260; i++) begin
      a = $urandom;
      a[1:0] = 2'($urandom_range(1, 3));
      issue(1'b1, 1'b0, a, 32'h0, 1, 32'h0);
    end
    idle(1);
    check("errcnt model", 32'(bus.errcnt), 32'(model_errcnt));
    check("errcnt saturated", 32'(bus.errcnt), 32'd255);

    // Reset in the 2nd REQ cycle abandons the transaction.
    bus.memread   = 1'b1;
    bus.memwrite  = 1'b0;
    bus.addr      = 32'h0000_0080;
    bus.writedata = 32'h0;
    p.ack_at = 10;
    p.rdata  = 32'hFEED_FACE;
    plan_q.push_back(p);
    seen = 0;
    for (int i = 0; i < 20 && seen < 2; i++) begin
      @(negedge clk);
      if (bus.mem_req) seen++;
    end
    check("reached 2nd REQ cycle", 32'(seen), 32'd2);
    #1 reset = 1'b0;
    #1;
    check("async reset mem_req", 32'(bus.mem_req), 32'd0);
    check("async reset busy", 32'(bus.busy), 32'd0);
    check("async reset memready", 32'(bus.memready), 32'd0);
    check("async reset readdata", bus.readdata, 32'd0);
    check("async reset errcnt", 32'(bus.errcnt), 32'd0);
    check("async reset mem_addr", bus.mem_addr, 32'd0);
    check("async reset mem_we", 32'(bus.mem_we), 32'd0);
    model_readdata = '0;
    model_errcnt   = '0;
    bus.memread    = 1'b0;
    repeat (2) @(negedge clk);
    reset     = 1'b1;
    force_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("late ack memready", 32'(bus.memready), 32'd0);
      check("late ack busy", 32'(bus.busy), 32'd0);
      check("late ack mem_req", 32'(bus.mem_req), 32'd0);
      check("late ack readdata", bus.readdata, 32'd0);
      check("late ack errcnt", 32'(bus.errcnt), 32'd0);
    end
    force_ack = 1'b0;

    idle(2);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    finish_test();
  end

endmodule
